acc_sat: RTL and testbench
==========================

// Module: acc_sat
// PURPOSE
//   Signed saturating block accumulator, downstream of the add_s adder.
//   Sums N accepted signed samples into a WIDTH-bit accumulator using add_s.
//   Clamps to the signed extremes whenever add_s flags of/uf.
//   Presents each block result on a valid/ready output, with sticky overflow/underflow flags.
// PARAMETERS
//   WIDTH   4   sample/accumulator width, two's complement signed
//   N       2   samples per block, N >= 1 (elaboration error otherwise)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   clr        in   1      synchronous block abort/clear
//   in_valid   in   1      sample x valid
//   in_ready   out  1      block accepts x this cycle
//   x          in   WIDTH  signed sample
//   out_valid  out  1      acc/of_flag/uf_flag hold a finished block result
//   out_ready  in   1      consumer takes result
//   acc        out  WIDTH  signed accumulator / block result
//   of_flag    out  1      sticky: at least one positive clamp in this block
//   uf_flag    out  1      sticky: at least one negative clamp in this block
// BEHAVIOUR
//   - Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
//   - Reset state (rst=1 at an edge):
//       state=ACC, acc=0, cnt=0, of_flag=0, uf_flag=0, out_valid=0, in_ready=1.
//       Reset mid-block discards all partial state.
//   - FSM, 2 states:
//       ACC:  in_ready=1, out_valid=0.
//             Accept = in_valid & in_ready.
//             On accept: acc <= sat(acc + x); cnt++.
//             The accept with cnt==N-1 sets cnt=0 and moves to HOLD.
//       HOLD: in_ready=0, out_valid=1; acc and flags stable.
//             On out_ready: acc=0, flags=0, go to ACC.
//             Back-to-back blocks therefore cost one bubble cycle.
//   - Saturation (via add_s: x=acc, y=x; sum, of, uf):
//       of=1 -> acc <= 2^(WIDTH-1)-1 and of_flag <= 1.
//       uf=1 -> acc <= -2^(WIDTH-1) and uf_flag <= 1.
//       else -> acc <= sum.
//       of and uf never both 1; if both are seen, of wins (assertion in bench).
//   - Latency: result visible (out_valid=1) in the cycle after the Nth accept.
//   - clr=1: same effect as rst on state/acc/cnt/flags/out_valid.
//       Overrides a same-cycle accept and a same-cycle out_ready handshake.
//       A pending HOLD result is dropped.
//   - in_valid while in HOLD: ignored (in_ready=0). Upstream must hold x.
//   - out_ready while in ACC: ignored.
//   - Clamped acc keeps accumulating: e.g. max, then +(-1) gives max-1.
//   - cnt width: $clog2(N) bits, minimum 1. Wraps only via the N-1 -> 0 rule.
// STRUCTURE
//   - acc_sat_pkg:
//       typedef enum logic {ACC, HOLD} acc_state_t;
//       functions sat_max(WIDTH) and sat_min(WIDTH) returning the signed extremes.
//   - One sub-module: the existing add_s, parameterised with WIDTH.
//   - Remaining logic in this file:
//       registers acc, cnt, state, of_flag, uf_flag;
//       a single always_ff;
//       the saturation mux in always_comb.
// TESTING (WIDTH=4, N=2, out_ready=1 unless stated)
//   1. rst held 2 cycles
//      -> acc=0, out_valid=0, in_ready=1, flags=0.
//   2. x=3 then x=-5 (consecutive accepts)
//      -> next cycle out_valid=1, acc=-2, of=0, uf=0; then back to ACC with acc=0.
//   3. x=3 then x=6
//      -> acc=7, of_flag=1, uf_flag=0.
//   4. x=-7 then x=-4
//      -> acc=-8, uf_flag=1, of_flag=0.
//   5. x=7, x=7 with out_ready=0 for 3 cycles
//      -> out_valid and acc=7 stable and in_ready=0 for all 3 cycles;
//         in_valid pulses in that window are not accepted.
//   6. x=5, then clr=1 together with in_valid, x=2
//      -> acc=0, cnt=0, no result.
//      Then x=1, x=1 -> acc=2.
//      rst asserted while in HOLD -> out_valid=0 next cycle.

Source files
------------

// File: rtl/acc_sat_pkg.sv
// Package: acc_sat_pkg
//   Shared types and helpers for the saturating block accumulator.
//   acc_state_t : block FSM states (ACC = collecting samples, HOLD = result offered)
//   sat_max/min : signed extremes of a two's complement word of a given width
package acc_sat_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_t;

    // Largest positive value representable in 'width' bits: 2^(width-1)-1.
    function automatic int sat_max(input int width);
        return (1 <<< (width - 1)) - 1;
    endfunction

    // Most negative value representable in 'width' bits: -2^(width-1).
    function automatic int sat_min(input int width);
        return -(1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/acc_sat_if.sv
// Interface: acc_sat_if
//   Sample input and block-result output handshakes of acc_sat.
//   in_valid/in_ready/x                 : sample stream into the accumulator
//   out_valid/out_ready                 : block result handshake
//   acc/of_flag/uf_flag                 : block result and sticky clamp flags
//   master : producer/consumer side (drives samples, takes results)
//   slave  : accumulator side
interface acc_sat_if #(
    parameter int WIDTH = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] x;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] acc;
    logic                    of_flag;
    logic                    uf_flag;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, acc, of_flag, uf_flag
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, acc, of_flag, uf_flag
    );
endinterface

// File: rtl/acc_sat_add_s.sv
// Module: add_s
//   Signed WIDTH-bit adder with overflow/underflow detection.
//   x, y : signed operands
//   sum  : wrapped two's complement sum
//   of   : true sum exceeded the positive extreme (two non-negatives gave a negative)
//   uf   : true sum fell below the negative extreme (two negatives gave a non-negative)
//   of and uf are mutually exclusive by construction.
module add_s #(
    parameter int WIDTH = 4
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    output logic signed [WIDTH-1:0] sum,
    output logic                    of,
    output logic                    uf
);
    assign sum = x + y;
    assign of  = ~x[WIDTH-1] & ~y[WIDTH-1] &  sum[WIDTH-1];
    assign uf  =  x[WIDTH-1] &  y[WIDTH-1] & ~sum[WIDTH-1];
endmodule

// File: rtl/acc_sat.sv
// Module: acc_sat
//   Signed saturating block accumulator. Sums N accepted samples, clamping
//   to the signed extremes on overflow/underflow, then offers the block
//   result on a valid/ready output together with sticky clamp flags.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   clr  : synchronous block abort; same effect as rst, beats any handshake
//   bus  : acc_sat_if slave (sample input, result output, flags)
module acc_sat
    import acc_sat_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N     = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    acc_sat_if.slave  bus
);
    localparam int             CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic signed [WIDTH-1:0] ACC_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic signed [WIDTH-1:0] ACC_MIN = WIDTH'(sat_min(WIDTH));

    if (N < 1) begin : g_bad_n
        $error("acc_sat: N must be >= 1");
    end

    acc_state_t              state_q, state_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    of_flag_q, of_flag_d;
    logic                    uf_flag_q, uf_flag_d;

    logic signed [WIDTH-1:0] add_sum;
    logic                    add_of;
    logic                    add_uf;
    logic signed [WIDTH-1:0] acc_sat_val;

    add_s #(.WIDTH(WIDTH)) u_add (
        .x   (acc_q),
        .y   (bus.x),
        .sum (add_sum),
        .of  (add_of),
        .uf  (add_uf)
    );

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        acc_sat_val = add_sum;
        if (add_of) begin
            acc_sat_val = ACC_MAX;
        end else if (add_uf) begin
            acc_sat_val = ACC_MIN;
        end
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        of_flag_d     = of_flag_q;
        uf_flag_d     = uf_flag_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;

        case (state_q)
            ACC: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    acc_d     = acc_sat_val;
                    of_flag_d = of_flag_q | add_of;
                    uf_flag_d = uf_flag_q | add_uf;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    acc_d     = '0;
                    of_flag_d = 1'b0;
                    uf_flag_d = 1'b0;
                    state_d   = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q   <= ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            of_flag_q <= 1'b0;
            uf_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            of_flag_q <= of_flag_d;
            uf_flag_q <= uf_flag_d;
        end
    end

    assign bus.acc     = acc_q;
    assign bus.of_flag = of_flag_q;
    assign bus.uf_flag = uf_flag_q;
endmodule

// File: tb/tb_acc_sat.sv
// Testbench: tb_acc_sat
//   Directed scenarios followed by randomized blocks checked against an
//   arithmetic reference model of the saturating block sum.
module tb_acc_sat;
    localparam int WIDTH = 4;
    localparam int N     = 2;
    localparam int MAXV  = 2 ** (WIDTH - 1) - 1;
    localparam int MINV  = -(2 ** (WIDTH - 1));

    logic clk;
    logic rst;
    logic clr;

    int n_total;
    int n_pass;

    acc_sat_if #(.WIDTH(WIDTH)) bus ();

    acc_sat #(.WIDTH(WIDTH), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: inputs were set at a falling edge, outputs are sampled at the next one.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Two back-to-back accepted samples.
    task automatic feed2(input int a, input int b);
        bus.in_valid = 1'b1;
        bus.x        = WIDTH'(a);
        tick();
        bus.x        = WIDTH'(b);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input int exp_acc,
                                input int exp_of, input int exp_uf);
        check({tag, ".out_valid"}, bus.out_valid, 1);
        check({tag, ".in_ready"}, bus.in_ready, 0);
        check({tag, ".acc"}, bus.acc, exp_acc);
        check({tag, ".of"}, bus.of_flag, exp_of);
        check({tag, ".uf"}, bus.uf_flag, exp_uf);
        check({tag, ".excl"}, bus.of_flag & bus.uf_flag, 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".out_valid"}, bus.out_valid, 0);
        check({tag, ".in_ready"}, bus.in_ready, 1);
        check({tag, ".acc"}, bus.acc, 0);
    endtask

    // Reference: running sum in plain integers, clamped to the signed range after each add.
    function automatic void ref_block(input int xs[N], output int s,
                                      output int o, output int u);
        s = 0;
        o = 0;
        u = 0;
        for (int i = 0; i < N; i++) begin
            s = s + xs[i];
            if (s > MAXV) begin
                s = MAXV;
                o = 1;
            end else if (s < MINV) begin
                s = MINV;
                u = 1;
            end
        end
    endfunction

    initial begin
        int xs[N];
        int e_acc;
        int e_of;
        int e_uf;
        int gap;
        int hold;

        n_total       = 0;
        n_pass        = 0;
        rst           = 1'b1;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.out_ready = 1'b1;

        // Reset held two cycles.
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");
        check("reset.of", bus.of_flag, 0);
        check("reset.uf", bus.uf_flag, 0);

        // Plain sum, then release with out_ready=1.
        feed2(3, -5);
        check_result("sum", -2, 0, 0);
        tick();
        check_idle("sum.release");

        // Positive clamp.
        feed2(3, 6);
        check_result("ovf", 7, 1, 0);
        tick();
        check_idle("ovf.release");

        // Negative clamp.
        feed2(-7, -4);
        check_result("unf", -8, 0, 1);
        tick();
        check_idle("unf.release");

        // Result held while out_ready=0; in_valid pulses must be ignored.
        bus.out_ready = 1'b0;
        feed2(7, 7);
        for (int i = 0; i < 3; i++) begin
            check_result("hold", 7, 1, 0);
            bus.in_valid = (i != 1);
            bus.x        = WIDTH'(-3);
            tick();
        end
        bus.in_valid = 1'b0;
        check_result("hold.end", 7, 1, 0);
        bus.out_ready = 1'b1;
        tick();
        check_idle("hold.release");

        // clr together with an accept aborts the partial block.
        bus.in_valid = 1'b1;
        bus.x        = WIDTH'(5);
        tick();
        clr   = 1'b1;
        bus.x = WIDTH'(2);
        tick();
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        check_idle("clr");
        check("clr.of", bus.of_flag, 0);
        // Counter must restart: one sample alone gives no result.
        bus.in_valid = 1'b1;
        bus.x        = WIDTH'(1);
        tick();
        check("clr.cnt0", bus.out_valid, 0);
        tick();
        bus.in_valid = 1'b0;
        check_result("clr.next", 2, 0, 0);
        tick();
        check_idle("clr.next.release");

        // clr in HOLD beats a same-cycle out_ready handshake and drops the result.
        bus.out_ready = 1'b0;
        feed2(4, 2);
        check_result("clrhold", 6, 0, 0);
        clr           = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        clr = 1'b0;
        check_idle("clrhold");

        // Reset in HOLD drops the result.
        bus.out_ready = 1'b0;
        feed2(-2, -3);
        check_result("rsthold", -5, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rsthold");

        // Randomized blocks with input gaps and output back-pressure.
        for (int blk = 0; blk < 30; blk++) begin
            bus.out_ready = 1'b0;
            for (int i = 0; i < N; i++) begin
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) begin
                    bus.in_valid = 1'b0;
                    tick();
                    check("rnd.gap.out_valid", bus.out_valid, 0);
                end
                xs[i]        = int'($urandom_range(0, 15)) + MINV;
                bus.in_valid = 1'b1;
                bus.x        = WIDTH'(xs[i]);
                tick();
            end
            bus.in_valid = 1'b0;
            ref_block(xs, e_acc, e_of, e_uf);
            check_result("rnd", e_acc, e_of, e_uf);
            hold = int'($urandom_range(0, 3));
            for (int h = 0; h < hold; h++) begin
                bus.in_valid = $urandom_range(0, 1) == 1;
                bus.x        = WIDTH'(int'($urandom_range(0, 15)));
                tick();
                check_result("rnd.hold", e_acc, e_of, e_uf);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            tick();
            check_idle("rnd.release");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
